// File: rtl/periph_bus_bridge.sv
// Byte-command to peripheral-bus bridge: header byte selects read/write and address,
// writes carry 4 data bytes LSB-first, reads return 4 bytes LSB-first.
// Optional macro BUS_BRIDGE_ACK_EN: writes return a single 0xA5 acknowledge byte.
module periph_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [4:0]  A,
    output logic [31:0] WD,
    output logic        WE,
    input  logic [31:0] RD,
    output logic        busy
);

    localparam int unsigned TMO_W = 32;

    typedef enum logic [1:0] {IDLE, GET_DATA, ACCESS, SEND} state_t;

    state_t             state;
    logic               is_write;
    logic [1:0]         byte_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [23:0]        wd_shift;
    logic [31:0]        resp;

    // Handshake and status flags depend on state alone
    assign rx_ready = (state == IDLE) || (state == GET_DATA);
    assign tx_valid = (state == SEND);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            is_write <= 1'b0;
            byte_cnt <= 2'd0;
            tmo_cnt  <= '0;
            wd_shift <= '0;
            resp     <= '0;
            A        <= '0;
            WD       <= '0;
            WE       <= 1'b0;
            tx_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        A        <= rx_data[4:0];
                        is_write <= rx_data[7];
                        byte_cnt <= 2'd0;
                        tmo_cnt  <= '0;
                        state    <= rx_data[7] ? GET_DATA : ACCESS;
                    end
                end
                GET_DATA: begin
                    if (rx_valid) begin
                        tmo_cnt  <= '0;
                        byte_cnt <= byte_cnt + 2'd1;
                        // WD is only updated as a whole word so it holds outside ACCESS
                        if (byte_cnt == 2'd3) begin
                            WD    <= {rx_data, wd_shift};
                            WE    <= 1'b1;
                            state <= ACCESS;
                        end else begin
                            wd_shift <= {rx_data, wd_shift[23:8]};
                        end
                    end else if (TIMEOUT_CYCLES != 0) begin
                        if (tmo_cnt >= TMO_W'(TIMEOUT_CYCLES - 1)) begin
                            tmo_cnt <= '0;
                            state   <= IDLE;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end
                end
                ACCESS: begin
                    WE       <= 1'b0;
                    byte_cnt <= 2'd0;
                    if (is_write) begin
`ifdef BUS_BRIDGE_ACK_EN
                        tx_data <= 8'hA5;
                        state   <= SEND;
`else
                        state   <= IDLE;
`endif
                    end else begin
                        resp    <= RD;
                        tx_data <= RD[7:0];
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        if (is_write || byte_cnt == 2'd3) begin
                            state <= IDLE;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                            resp     <= {8'h00, resp[31:8]};
                            tx_data  <= resp[15:8];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
